// File: rtl/adder_io_arbiter.sv
// rtl/adder_io_arbiter.sv - round-robin arbiter sequencing two requesters onto one shared multi-cycle adder
// Results are published on io_out and held for HOLD_CYCLES before the next grant.
module adder_io_arbiter #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_op0,
  input  logic [WIDTH-1:0] a_op1,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_op0,
  input  logic [WIDTH-1:0] b_op1,
  output logic             b_ready,
  output logic             add_start,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  input  logic             add_done,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_err,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_oeb,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] WD_LAST   = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] hold_cnt, wd_cnt;
  logic       last_grant, cur_id;
  logic       grant_a, grant_b, accept;
  logic       finish_ok, finish_err, hold_exit;

  // last_grant: 0 = A, 1 = B; on a tie the requester not served last wins
  always_comb begin
    grant_a = a_valid;
    grant_b = b_valid;
    if (a_valid && b_valid) begin
      grant_a = last_grant;
      grant_b = !last_grant;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    add_start  = 1'b0;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    hold_exit  = 1'b0;
    case (state)
      S_IDLE: begin
        // ready is combinational from valid, so keep it quiet while reset is held
        a_ready = grant_a && resetb;
        b_ready = grant_b && resetb;
        if (grant_a || grant_b) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        add_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (add_done) begin
          finish_ok = 1'b1;
          state_nxt = S_HOLD;
        end else if (wd_cnt == WD_LAST) begin
          finish_err = 1'b1;
          state_nxt  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          hold_exit = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy   = (state != S_IDLE);
  assign accept = a_ready || b_ready;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      add_x      <= '0;
      add_y      <= '0;
      cur_id     <= 1'b0;
      last_grant <= 1'b1;
      wd_cnt     <= 8'd0;
      hold_cnt   <= 8'd0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_err    <= 1'b0;
      io_out     <= '0;
      io_oeb     <= '1;
    end else begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      if (accept) begin
        cur_id <= b_ready;
        add_x  <= b_ready ? b_op0 : a_op0;
        add_y  <= b_ready ? b_op1 : a_op1;
      end
      if (state == S_ISSUE)     wd_cnt <= 8'd0;
      else if (state == S_WAIT) wd_cnt <= wd_cnt + 8'd1;
      if (finish_ok || finish_err) begin
        rsp_valid <= 1'b1;
        rsp_id    <= cur_id;
        rsp_err   <= finish_err;
        hold_cnt  <= 8'd0;
      end else if (state == S_HOLD) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
      // an aborted operation leaves the published pins untouched
      if (finish_ok) begin
        rsp_sum  <= add_sum;
        rsp_cout <= add_cout;
        io_out   <= add_sum;
        io_oeb   <= '0;
      end
      if (hold_exit) last_grant <= cur_id;
    end
  end

endmodule

// File: tb/tb_adder_io_arbiter.sv
// tb/tb_adder_io_arbiter.sv - self-checking bench for adder_io_arbiter
// Behavioural adder, scoreboard model of grants/results, vector table and directed corner cases.
module tb_adder_io_arbiter;
  localparam int W    = 8;
  localparam int HOLD = 4;
  localparam int TMO  = 8;

  logic         clock, resetb;
  logic         a_valid, b_valid, a_ready, b_ready;
  logic [W-1:0] a_op0, a_op1, b_op0, b_op1;
  logic         add_start, add_done, add_cout;
  logic [W-1:0] add_x, add_y, add_sum;
  logic         rsp_valid, rsp_id, rsp_cout, rsp_err, busy;
  logic [W-1:0] rsp_sum, io_out, io_oeb;

  adder_io_arbiter #(.WIDTH(W), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)) dut (
    .clock(clock), .resetb(resetb),
    .a_valid(a_valid), .a_op0(a_op0), .a_op1(a_op1), .a_ready(a_ready),
    .b_valid(b_valid), .b_op0(b_op0), .b_op1(b_op1), .b_ready(b_ready),
    .add_start(add_start), .add_x(add_x), .add_y(add_y),
    .add_done(add_done), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_err(rsp_err),
    .io_out(io_out), .io_oeb(io_oeb), .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // behavioural adder: adder_cfg > 0 fixed latency, 0 random 1..10, < 0 never completes
  int adder_cfg = 1;
  int cur_lat   = 1;
  bit spur_done = 1'b0;

  initial begin : adder_model
    int         cnt;
    logic [8:0] res;
    bit         pend;
    pend = 1'b0; cnt = 0; res = '0;
    add_done = 1'b0; add_sum = '0; add_cout = 1'b0;
    forever begin
      @(negedge clock);
      if (!resetb) pend = 1'b0;
      else if (add_start) begin
        if (adder_cfg > 0)       cur_lat = adder_cfg;
        else if (adder_cfg == 0) cur_lat = $urandom_range(1, 10);
        else                     cur_lat = 100000;
        cnt  = cur_lat;
        res  = {1'b0, add_x} + {1'b0, add_y};
        pend = 1'b1;
      end
      @(posedge clock); #1;
      add_done = spur_done;
      add_sum  = 8'($urandom);
      add_cout = 1'($urandom);
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          add_done = 1'b1;
          {add_cout, add_sum} = res;
          pend = 1'b0;
        end
      end
    end
  end

  // scoreboard: who should be granted, when the block is idle, and what each response carries
  typedef struct {
    bit         id;
    logic [7:0] sum;
    bit         cout;
    int         acc_cyc;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  bit         ref_last, ref_idle, eid, exp_err;
  logic [7:0] ref_io, ref_oeb;
  logic [8:0] s9;
  int         last_rsp_cyc;

  always @(negedge clock) begin
    if (!resetb) begin
      q.delete();
      ref_last     = 1'b1;
      ref_io       = 8'h00;
      ref_oeb      = 8'hFF;
      last_rsp_cyc = -1000;
    end else begin
      ref_idle = (q.size() == 0) && (cyc - last_rsp_cyc >= HOLD);
      chk("busy", busy, !ref_idle);
      chk("a_ready", a_ready, ref_idle && a_valid && (!b_valid || ref_last));
      chk("b_ready", b_ready, ref_idle && b_valid && (!a_valid || !ref_last));
      if ((a_ready && a_valid) || (b_ready && b_valid)) begin
        eid = b_ready;
        s9  = eid ? ({1'b0, b_op0} + {1'b0, b_op1}) : ({1'b0, a_op0} + {1'b0, a_op1});
        q.push_back('{eid, s9[7:0], s9[8], cyc});
        ref_last = eid;
      end
      if (rsp_valid) begin
        if (q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          e       = q.pop_front();
          exp_err = (cur_lat > TMO);
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_err", rsp_err, exp_err);
          chk("rsp_latency", cyc - e.acc_cyc, 2 + (exp_err ? TMO : cur_lat));
          if (!exp_err) begin
            chk("rsp_sum", rsp_sum, e.sum);
            chk("rsp_cout", rsp_cout, e.cout);
            ref_io  = e.sum;
            ref_oeb = 8'h00;
          end
          last_rsp_cyc = cyc;
        end
      end
      chk("io_out", io_out, ref_io);
      chk("io_oeb", io_oeb, ref_oeb);
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic send(input bit is_b, input logic [7:0] x, input logic [7:0] y, output int ac);
    int n;
    n = 0;
    if (is_b) begin b_valid = 1'b1; b_op0 = x; b_op1 = y; end
    else      begin a_valid = 1'b1; a_op0 = x; a_op1 = y; end
    @(negedge clock);
    while (!(is_b ? b_ready : a_ready) && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("accept_seen", is_b ? b_ready : a_ready, 1);
    ac = cyc;
    tick();
  endtask

  task automatic wait_rsp(output int rc);
    int n;
    n = 0;
    @(negedge clock);
    while (!rsp_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("rsp_arrived", rsp_valid, 1);
    rc = cyc;
  endtask

  task automatic spur();
    @(negedge clock); spur_done = 1'b1;
    @(negedge clock); spur_done = 1'b0;
  endtask

  typedef struct {
    logic [7:0] x, y, sum;
    logic       cout;
  } vec_t;

  vec_t vt[12];
  int   ac, rc;
  bit   tie_exp[4];

  initial begin
    for (int i = 0; i < 10; i++) vt[i] = '{8'(i), 8'h01, 8'(i + 1), 1'b0};
    vt[10] = '{8'hFE, 8'h01, 8'hFF, 1'b0};
    vt[11] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    tie_exp = '{1'b0, 1'b1, 1'b0, 1'b1};

    resetb = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_op0 = '0; a_op1 = '0; b_op0 = '0; b_op1 = '0;
    repeat (3) @(negedge clock);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_add_start", add_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_cout", rsp_cout, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_add_x", add_x, 0);
    chk("rst_add_y", add_y, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_io_out", io_out, 0);
    chk("rst_io_oeb", io_oeb, 8'hFF);
    tick();
    resetb = 1'b1;
    tick();

    // single requester A, 1-cycle adder, back-to-back requests
    for (int i = 0; i < 12; i++) begin
      send(1'b0, vt[i].x, vt[i].y, ac);
      if (i > 0) chk("hold_exact", ac - rc, HOLD);
      wait_rsp(rc);
      chk("vec_latency", rc - ac, 3);
      chk("vec_id", rsp_id, 0);
      chk("vec_err", rsp_err, 0);
      chk("vec_sum", rsp_sum, vt[i].sum);
      chk("vec_cout", rsp_cout, vt[i].cout);
      chk("vec_io_out", io_out, vt[i].sum);
      chk("vec_io_oeb", io_oeb, 8'h00);
      tick();
    end
    a_valid = 1'b0;
    repeat (HOLD + 2) tick();

    // both requesters valid continuously from reset: A,B,A,B
    resetb = 1'b0;
    tick();
    a_valid = 1'b1; a_op0 = 8'h11; a_op1 = 8'h22;
    b_valid = 1'b1; b_op0 = 8'h40; b_op1 = 8'h05;
    tick();
    resetb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(rc);
      chk("tie_order", rsp_id, tie_exp[i]);
      chk("tie_sum", rsp_sum, tie_exp[i] ? 8'h45 : 8'h33);
    end
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (HOLD + 2) tick();

    // dead adder: abort on timeout, late completion ignored, next request normal
    adder_cfg = -1;
    send(1'b0, 8'h10, 8'h20, ac);
    a_valid = 1'b0;
    wait_rsp(rc);
    chk("to_err", rsp_err, 1);
    chk("to_latency", rc - ac, 2 + TMO);
    chk("to_io_out", io_out, 8'h45);
    spur();
    tick();
    adder_cfg = 1;
    repeat (HOLD) tick();
    send(1'b1, 8'h70, 8'h0F, ac);
    b_valid = 1'b0;
    wait_rsp(rc);
    chk("after_to_err", rsp_err, 0);
    chk("after_to_id", rsp_id, 1);
    chk("after_to_sum", rsp_sum, 8'h7F);
    chk("after_to_io", io_out, 8'h7F);
    repeat (HOLD + 2) tick();

    // spurious completion while idle
    spur();
    repeat (3) @(negedge clock);
    chk("spur_idle_busy", busy, 0);
    chk("spur_idle_io", io_out, 8'h7F);
    tick();

    // reset in the middle of WAIT
    adder_cfg = -1;
    send(1'b0, 8'h01, 8'h02, ac);
    repeat (3) tick();
    resetb = 1'b0;
    #1;
    chk("rst_wait_busy", busy, 0);
    chk("rst_wait_io_oeb", io_oeb, 8'hFF);
    chk("rst_wait_io_out", io_out, 8'h00);
    chk("rst_wait_rsp_valid", rsp_valid, 0);
    chk("rst_wait_a_ready", a_ready, 0);
    chk("rst_wait_add_start", add_start, 0);
    b_valid = 1'b1; b_op0 = 8'h03; b_op1 = 8'h04;
    adder_cfg = 1;
    repeat (2) tick();
    resetb = 1'b1;
    @(negedge clock);
    chk("rst_tie_a", a_ready, 1);
    chk("rst_tie_b", b_ready, 0);
    wait_rsp(rc);
    chk("rst_tie_id", rsp_id, 0);
    chk("rst_tie_sum", rsp_sum, 8'h03);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (HOLD + 2) tick();

    // randomized traffic with random adder latency (some exceeding the timeout)
    adder_cfg = 0;
    for (int i = 0; i < 600; i++) begin
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 3) != 0);
      a_op0 = 8'($urandom); a_op1 = 8'($urandom);
      b_op0 = 8'($urandom); b_op1 = 8'($urandom);
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (40) tick();
    @(negedge clock);
    chk("drain_queue", q.size(), 0);
    chk("drain_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_io_arbiter.md
# adder_io_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle adder between two requesters and publishes each result on the user-area IO pins. Sits in the user project between the wishbone-side and logic-analyzer-side operand sources and the shared adder; its io_out/io_oeb drive the low mprj_io bits that the chip-level IO-port bench watches.

## Interface
- WIDTH, 8: operand, sum and IO width.
- HOLD_CYCLES, 16: cycles each result is held on io_out before the next grant; legal range 1..255.
- TIMEOUT, 64: WAIT-state cycles allowed for add_done before abort; legal range 2..255.

- clock  in  1  single clock, all state on rising edge.
- resetb  in  1  asynchronous active-low reset.
- a_valid / b_valid  in  1  requester A/B has operands.
- a_op0, a_op1 / b_op0, b_op1  in  WIDTH  operands.
- a_ready / b_ready  out  1  one-cycle accept strobe; transfer when valid & ready.
- add_start  out  1  one-cycle pulse launching the shared adder.
- add_x, add_y  out  WIDTH  latched operands, stable from ISSUE until HOLD exit.
- add_done  in  1  adder completion, sampled only in WAIT.
- add_sum  in  WIDTH; add_cout  in  1  adder result, valid with add_done.
- rsp_valid  out  1  one-cycle result pulse.
- rsp_id  out  1  0 = A, 1 = B.
- rsp_sum  out  WIDTH; rsp_cout, rsp_err  out  1.
- io_out  out  WIDTH  published sum.
- io_oeb  out  WIDTH  pad output-enable, active-low.
- busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE: if exactly one valid, grant it; if both, grant the one not granted last (last_grant resets to B, so A wins the first tie). Assert the granted ready combinationally in that cycle, latch operands and id, go ISSUE. Ungranted ready stays 0.
- ISSUE: add_start = 1 for one cycle, add_x/add_y = latched operands; clear watchdog; go WAIT.
- WAIT: on add_done, latch add_sum/add_cout, go HOLD with err = 0. Watchdog reaching TIMEOUT without add_done: go HOLD with err = 1.
- HOLD entry cycle: rsp_valid = 1, rsp_id/rsp_sum/rsp_cout/rsp_err valid that cycle only (rsp_sum/rsp_cout retain value afterwards). On success io_out <= sum and io_oeb <= all 0 (stays 0 until reset). On error io_out, io_oeb unchanged. Count HOLD_CYCLES cycles, then IDLE; update last_grant on leaving HOLD.
- add_done outside WAIT (late after abort, spurious) is ignored; no state change.
- Sum width: WIDTH bits modulo 2^WIDTH, carry only on rsp_cout; block never computes, it trusts add_sum.
- Requester dropping valid before grant: no transfer, no state change.
- Reset (any state, including mid-WAIT): all outputs to reset values immediately, in-flight operation discarded, no rsp_valid.
- Reset values: a_ready, b_ready, add_start, rsp_valid, rsp_id, rsp_cout, rsp_err, busy = 0; add_x, add_y, rsp_sum, io_out = 0; io_oeb = all 1; state IDLE; last_grant = B.

## Timing
- Accept at cycle T; add_start at T+1; WAIT from T+2.
- add_done sampled high at cycle D: HOLD entry D+1 with rsp_valid and io_out updated at D+1.
- Fastest adder (add_done at T+2): result at T+3.
- HOLD occupies D+1..D+HOLD_CYCLES; IDLE at D+HOLD_CYCLES+1, next accept that same cycle earliest.
- Timeout: add_done absent for TIMEOUT WAIT cycles: rsp_err pulse on cycle T+2+TIMEOUT.
- Throughput: one operation per (3 + adder latency + HOLD_CYCLES) cycles minimum.

## Test plan
- Single requester A, ops (0x00,0x01) then (0x01,0x01)...(0x09,0x01), 1-cycle adder -> io_out steps 0x01..0x0A, each held exactly HOLD_CYCLES, rsp_id = 0, io_oeb = 0x00 after first result.
- A = (0xFE,0x01), then (0xFF,0x01) -> io_out 0xFF cout 0, then 0x00 with rsp_cout = 1.
- A and B valid continuously from reset -> grants A,B,A,B; rsp_id alternates starting 0; never two readies in one cycle.
- Adder never asserts add_done, TIMEOUT=8 -> rsp_err = 1 on T+10, io_out unchanged, late add_done afterwards ignored, next request served normally.
- resetb low during WAIT -> io_oeb = 0xFF, io_out = 0x00, busy = 0 immediately; no rsp_valid; first tie after reset goes to A.
- add_done pulsed during IDLE and HOLD -> no state or output change.
